// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-path scheduler.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    ACTIVE,
    GAP
  } sched_state_t;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = int'(i) + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker
  import uart_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  localparam int unsigned NU = N;

  int unsigned w_idx;

  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NU; k++) begin
      w_idx = (32'(ptr) + k) % NU;
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        grant[w_idx] = 1'b1;
        gnt_idx      = IW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between N_REQ requesters: round-robin grant,
// frame tracking via the transmitter's busy, inter-frame gap and start timeout.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int DW            = UART_DW,
  parameter int GAP_TICKS     = 1,
  parameter int TIMEOUT_TICKS = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    TX_tick,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DW-1:0]     req_data,
  input  logic [N_REQ-1:0]        req_par_en,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_transmit,
  output logic [DW-1:0]           tx_data,
  output logic                    tx_par_en,
  input  logic                    tx_busy,
  output logic                    tx_done,
  output logic                    tx_err,
  output logic [clog2(N_REQ)-1:0] tx_id,
  output logic                    active
);

  localparam int IW      = clog2(N_REQ);
  localparam int GAP_EFF = (GAP_TICKS < 1) ? 1 : GAP_TICKS;
  localparam int TO_EFF  = (TIMEOUT_TICKS < 1) ? 1 : TIMEOUT_TICKS;
  localparam int GW      = clog2(GAP_EFF + 1);
  localparam int TW      = clog2(TO_EFF + 1);

  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_EFF - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_EFF - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

  sched_state_t r_state, w_next;

  logic [IW-1:0]    r_rr_ptr;
  logic [TW-1:0]    r_to_cnt;
  logic [GW-1:0]    r_gap_cnt;
  logic [DW-1:0]    r_data;
  logic             r_par;
  logic [IW-1:0]    r_id;
  logic             r_done;
  logic             r_err;

  logic [N_REQ-1:0] w_grant;
  logic [IW-1:0]    w_gnt_idx;
  logic             w_any;
  logic             w_take;
  logic             w_to_hit;
  logic             w_gap_hit;

  rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_picker (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .grant   (w_grant),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  // No grant while a done/err pulse is showing, so the two never coincide.
  assign w_take    = (r_state == IDLE) && RST && !r_done && !r_err && w_any;
  assign w_to_hit  = TX_tick && (r_to_cnt == TO_LAST);
  assign w_gap_hit = TX_tick && (r_gap_cnt == GAP_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_take) w_next = ISSUE;
      ISSUE: begin
        // busy takes priority over a timeout landing in the same cycle
        if (tx_busy)       w_next = ACTIVE;
        else if (w_to_hit) w_next = IDLE;
      end
      ACTIVE:  if (!tx_busy) w_next = GAP;
      GAP:     if (w_gap_hit) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    tx_transmit = 1'b0;
    active      = 1'b0;
    case (r_state)
      IDLE: if (w_take) req_ready = w_grant;
      ISSUE: begin
        tx_transmit = 1'b1;
        active      = 1'b1;
      end
      ACTIVE, GAP: active = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_rr_ptr  <= '0;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
      r_data    <= '0;
      r_par     <= 1'b0;
      r_id      <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= (r_state == GAP) && w_gap_hit;
      r_err  <= (r_state == ISSUE) && !tx_busy && w_to_hit;

      if (w_take) begin
        r_data   <= req_data[w_gnt_idx*DW +: DW];
        r_par    <= req_par_en[w_gnt_idx];
        r_id     <= w_gnt_idx;
        r_rr_ptr <= (w_gnt_idx == IDX_LAST) ? '0 : w_gnt_idx + 1'b1;
      end

      if (w_take)                               r_to_cnt <= '0;
      else if ((r_state == ISSUE) && TX_tick)   r_to_cnt <= r_to_cnt + 1'b1;

      if ((r_state == ACTIVE) && !tx_busy)      r_gap_cnt <= '0;
      else if ((r_state == GAP) && TX_tick)     r_gap_cnt <= r_gap_cnt + 1'b1;
    end
  end

  assign tx_data   = r_data;
  assign tx_par_en = r_par;
  assign tx_id     = r_id;
  assign tx_done   = r_done;
  assign tx_err    = r_err;

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART transmit path (FSM + serializer + parity + output mux) between `N_REQ` byte requesters. It grants one requester at a time and latches its byte and parity-enable. It drives the transmitter's `transmit`/`TX_DATA`/`par_EN` inputs and tracks the transmitter's `busy` output through one full frame. It inserts an inter-frame gap, then reports completion or a start timeout.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8).
- `DW`, 8, data width; must match the transmitter's `TX_DATA`.
- `GAP_TICKS`, 1, `TX_tick` pulses to wait after `busy` falls; minimum 1, values below 1 are treated as 1.
- `TIMEOUT_TICKS`, 4, `TX_tick` pulses to wait for `busy` to rise before abandoning a frame.

Ports:
- `CLK`, in, 1, clock.
- `RST`, in, 1, asynchronous, active-low reset.
- `TX_tick`, in, 1, baud-rate enable; the same signal that feeds the transmitter.
- `req_valid`, in, N_REQ, per-requester request.
- `req_data`, in, N_REQ*DW, requester i's byte is at bits [i*DW +: DW].
- `req_par_en`, in, N_REQ, per-requester parity enable.
- `req_ready`, out, N_REQ, one-hot, 1-cycle acceptance pulse.
- `tx_transmit`, out, 1, drives the transmitter's `transmit`.
- `tx_data`, out, DW, drives `TX_DATA`.
- `tx_par_en`, out, 1, drives `par_EN`.
- `tx_busy`, in, 1, the transmitter's `busy`.
- `tx_done`, out, 1, 1-cycle pulse when a frame completes.
- `tx_err`, out, 1, 1-cycle pulse on start timeout.
- `tx_id`, out, clog2(N_REQ), index of the current or last granted requester.
- `active`, out, 1, high in every state except IDLE.

## Operation
States:
- **IDLE**
  - If any `req_valid` is set, pick the first valid index at or after `rr_ptr`, wrapping.
  - Assert `req_ready[g]` combinationally in that cycle.
  - On that edge, latch `tx_data`, `tx_par_en` and `tx_id`, set `rr_ptr = (g+1) mod N_REQ`, and go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE**
  - `tx_transmit = 1`.
  - Count `TX_tick` pulses in `to_cnt`.
  - If `tx_busy == 1`, go to ACTIVE.
  - If `to_cnt` reaches `TIMEOUT_TICKS` with `tx_busy` still low, pulse `tx_err` and go to IDLE.
  - If both happen in the same cycle, `tx_busy` wins: go to ACTIVE, no error.
- **ACTIVE**
  - `tx_transmit = 0`.
  - When `tx_busy == 0`, go to GAP and clear `gap_cnt`. The transmitter is in its STOP state at that point.
- **GAP**
  - Count `TX_tick` pulses.
  - When the count reaches `GAP_TICKS`, pulse `tx_done` and go to IDLE.
  - The first tick returns the transmitter from STOP to IDLE.

Data rules:
- `tx_data`, `tx_par_en` and `tx_id` stay stable from the grant edge until the next grant; they are never changed mid-frame.
- Requesters may drop or change `req_valid`/`req_data` at any time except in their `req_ready` cycle. Requests arriving while `active` is high wait.

Reset (`RST` low, at any time, including mid-frame):
- State returns to IDLE and `rr_ptr` to 0.
- All outputs go to 0: `req_ready`, `tx_transmit`, `tx_data`, `tx_par_en`, `tx_done`, `tx_err`, `tx_id`, `active`.
- Both counters clear.
- The in-flight frame is abandoned, with no `tx_done` or `tx_err`.

## Timing
- Grant: `req_ready` is high in the cycle the request is observed in IDLE. `tx_transmit` is high from the next cycle.
- The transmitter enters START on the first `TX_tick` that sees `transmit`. `tx_busy` is visible one cycle after that tick, and ISSUE leaves in that cycle.
- Back-to-back frames: `tx_done` is registered and IDLE is re-entered in the same cycle. The next grant can occur in the cycle after `tx_done`.
- Minimum frame-to-frame spacing is `GAP_TICKS` baud ticks after `busy` falls.
- `tx_done`/`tx_err` are never asserted in the same cycle as `req_ready`.

## Structure
- Shared package `uart_pkg`:
  - state enum `sched_state_t` (IDLE, ISSUE, ACTIVE, GAP);
  - width constant `UART_DW = 8`;
  - function `clog2`.
- Sub-module `rr_picker`, combinational. Inputs: `req` vector and `ptr`. Outputs: `grant` one-hot, `gnt_idx` and `any`.
- This block holds the FSM, the counters, the latches and `rr_ptr`.

## Test plan
- **Single request:** `req_valid = 4'b0100`, `req_data[2] = 8'hA5`, `par_en = 1`; behavioural TX model.
  - `req_ready = 4'b0100` for one cycle.
  - `tx_data = 8'hA5`, `tx_par_en = 1`.
  - `tx_transmit` drops once `busy` rises.
  - `tx_done` follows one tick after `busy` falls, with `tx_id = 2`.
- **Fairness:** all four requesters held valid for 8 frames.
  - Grant order is 0, 1, 2, 3, 0, 1, 2, 3.
  - Exactly one `tx_done` per grant.
- **Timeout:** `tx_busy` tied to 0, `TIMEOUT_TICKS = 4`.
  - `tx_err` pulses on the 4th `TX_tick` after ISSUE.
  - State returns to IDLE and `rr_ptr` has advanced.
- **Late request:** requester 1 raises `valid` while requester 0's frame is ACTIVE.
  - No `req_ready[1]` until the cycle after `tx_done`.
  - `tx_data` stays unchanged during frame 0.
- **Reset mid-frame:** `RST` low during ACTIVE.
  - All outputs read 0 on the next sample.
  - After release, a valid on requester 3 is granted first, since `rr_ptr` is reset to 0.
- **Tie at timeout:** `tx_busy` rises in the same cycle as the 4th tick.
  - State goes to ACTIVE.
  - No `tx_err`.
